// File: rtl/sync_filter.sv
// Multi-channel synchronizer with per-channel glitch filter and edge pulses.
// Each channel is independent; a filtered output changes only after FILTER_LEN stable samples.
module sync_filter #(
    parameter int               WIDTH       = 1,
    parameter int               PIPE_LENGTH = 2,
    parameter int               FILTER_LEN  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             dest_clk_i,
    input  logic             dest_rst_i,
    input  logic [WIDTH-1:0] sig_i,
    output logic [WIDTH-1:0] sync_sig_o,
    output logic [WIDTH-1:0] filt_sig_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    localparam int CW_RAW = $clog2(FILTER_LEN + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [PIPE_LENGTH-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  w_raw;
    logic [WIDTH-1:0]                  w_filt;
    logic [WIDTH-1:0]                  w_rise;
    logic [WIDTH-1:0]                  w_fall;

    // Synchronizer shift register: stage 0 samples the pins, last stage is raw.
    always_ff @(posedge dest_clk_i) begin
        if (dest_rst_i) begin
            r_sync <= {PIPE_LENGTH{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[PIPE_LENGTH-2:0], sig_i};
        end
    end

    assign w_raw = r_sync[PIPE_LENGTH-1];

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        logic          r_filt;
        logic          r_rise;
        logic          r_fall;
        logic [CW-1:0] r_cnt;

        // Debounce counter: any return of raw to filt restarts the qualification.
        always_ff @(posedge dest_clk_i) begin
            if (dest_rst_i) begin
                r_filt <= RESET_VAL[g];
                r_cnt  <= '0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else if (w_raw[g] == r_filt) begin
                r_cnt  <= '0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else if (r_cnt == CNT_MAX) begin
                r_filt <= w_raw[g];
                r_cnt  <= '0;
                r_rise <= w_raw[g];
                r_fall <= ~w_raw[g];
            end else begin
                r_cnt  <= r_cnt + CNT_ONE;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end
        end

        assign w_filt[g] = r_filt;
        assign w_rise[g] = r_rise;
        assign w_fall[g] = r_fall;
    end

    assign sync_sig_o = w_raw;
    assign filt_sig_o = w_filt;
    assign rise_o     = w_rise;
    assign fall_o     = w_fall;

endmodule

// File: tb/tb_sync_filter.sv
// Directed self-checking bench for sync_filter: main config (2 ch, pipe 2, filter 4, reset 01)
// plus an alternate instance (1 ch, pipe 3, filter 1, reset 0).
module tb_sync_filter;

    logic       clk;
    logic       rst;
    logic [1:0] sig;
    logic [1:0] sync_o, filt_o, rise_o, fall_o;
    logic       sig_a;
    logic       sync_a, filt_a, rise_a, fall_a;

    int n_vec;
    int n_err;

    sync_filter #(
        .WIDTH(2), .PIPE_LENGTH(2), .FILTER_LEN(4), .RESET_VAL(2'b01)
    ) dut (
        .dest_clk_i(clk), .dest_rst_i(rst), .sig_i(sig),
        .sync_sig_o(sync_o), .filt_sig_o(filt_o), .rise_o(rise_o), .fall_o(fall_o)
    );

    sync_filter #(
        .WIDTH(1), .PIPE_LENGTH(3), .FILTER_LEN(1), .RESET_VAL(1'b0)
    ) dut_alt (
        .dest_clk_i(clk), .dest_rst_i(rst), .sig_i(sig_a),
        .sync_sig_o(sync_a), .filt_sig_o(filt_a), .rise_o(rise_a), .fall_o(fall_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then step off it so outputs are stable for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic [1:0] v);
        sig = v;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst = 1'b1;
        sig = 2'b10;
        sig_a = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            exp = {2'b01, 2'b01, 2'b00, 2'b00};
            n_vec++;
            if ({sync_o, filt_o, rise_o, fall_o} !== exp) begin
                n_err++;
                $display("FAIL reset_hold n=%0d got=%b want=%b", n, {sync_o, filt_o, rise_o, fall_o}, exp);
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp = {(n >= 2) ? 2'b10 : 2'b01, (n >= 6) ? 2'b10 : 2'b01,
                   (n == 6) ? 2'b10 : 2'b00, (n == 6) ? 2'b01 : 2'b00};
            n_vec++;
            if ({sync_o, filt_o, rise_o, fall_o} !== exp) begin
                n_err++;
                $display("FAIL reset_release n=%0d got=%b want=%b", n, {sync_o, filt_o, rise_o, fall_o}, exp);
            end
        end
    endtask

    task automatic test_clean_step();
        logic [7:0] exp;
        settle(2'b01);
        sig = 2'b11;
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp = {(n >= 2) ? 2'b11 : 2'b01, (n >= 6) ? 2'b11 : 2'b01,
                   (n == 6) ? 2'b10 : 2'b00, 2'b00};
            n_vec++;
            if ({sync_o, filt_o, rise_o, fall_o} !== exp) begin
                n_err++;
                $display("FAIL clean_step n=%0d got=%b want=%b", n, {sync_o, filt_o, rise_o, fall_o}, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] exp;
        // 3-cycle low on channel 0: rejected
        for (int n = 1; n <= 10; n++) begin
            sig = (n <= 3) ? 2'b10 : 2'b11;
            tick();
            exp = {1'b1, (n >= 2 && n <= 4) ? 1'b0 : 1'b1, 2'b11, 2'b00, 2'b00};
            n_vec++;
            if ({sync_o, filt_o, rise_o, fall_o} !== exp) begin
                n_err++;
                $display("FAIL glitch3 n=%0d got=%b want=%b", n, {sync_o, filt_o, rise_o, fall_o}, exp);
            end
        end
        // 4-cycle low on channel 0: accepted, then recovers
        for (int n = 1; n <= 12; n++) begin
            sig = (n <= 4) ? 2'b10 : 2'b11;
            tick();
            exp = {1'b1, (n >= 2 && n <= 5) ? 1'b0 : 1'b1,
                   1'b1, (n >= 6 && n <= 9) ? 1'b0 : 1'b1,
                   1'b0, (n == 10) ? 1'b1 : 1'b0,
                   1'b0, (n == 6) ? 1'b1 : 1'b0};
            n_vec++;
            if ({sync_o, filt_o, rise_o, fall_o} !== exp) begin
                n_err++;
                $display("FAIL glitch4 n=%0d got=%b want=%b", n, {sync_o, filt_o, rise_o, fall_o}, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp;
        settle(2'b01);
        sig = 2'b10;
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp = {(n >= 2) ? 2'b10 : 2'b01, (n >= 6) ? 2'b10 : 2'b01,
                   (n == 6) ? 2'b10 : 2'b00, (n == 6) ? 2'b01 : 2'b00};
            n_vec++;
            if ({sync_o, filt_o, rise_o, fall_o} !== exp) begin
                n_err++;
                $display("FAIL simult n=%0d got=%b want=%b", n, {sync_o, filt_o, rise_o, fall_o}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [7:0] exp;
        settle(2'b01);
        sig = 2'b10;
        for (int n = 1; n <= 6; n++) begin
            if (n == 6) rst = 1'b1;
            tick();
            exp = {(n >= 2 && n <= 5) ? 2'b10 : 2'b01, 2'b01, 2'b00, 2'b00};
            n_vec++;
            if ({sync_o, filt_o, rise_o, fall_o} !== exp) begin
                n_err++;
                $display("FAIL mid_count n=%0d got=%b want=%b", n, {sync_o, filt_o, rise_o, fall_o}, exp);
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp = {(n >= 2) ? 2'b10 : 2'b01, (n >= 6) ? 2'b10 : 2'b01,
                   (n == 6) ? 2'b10 : 2'b00, (n == 6) ? 2'b01 : 2'b00};
            n_vec++;
            if ({sync_o, filt_o, rise_o, fall_o} !== exp) begin
                n_err++;
                $display("FAIL mid_restart n=%0d got=%b want=%b", n, {sync_o, filt_o, rise_o, fall_o}, exp);
            end
        end
    endtask

    task automatic test_alt_config();
        logic [3:0] exp;
        sig_a = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            exp = {n >= 3, n >= 4, n == 4, 1'b0};
            n_vec++;
            if ({sync_a, filt_a, rise_a, fall_a} !== exp) begin
                n_err++;
                $display("FAIL alt_step n=%0d got=%b want=%b", n, {sync_a, filt_a, rise_a, fall_a}, exp);
            end
        end
        for (int n = 1; n <= 8; n++) begin
            sig_a = (n == 1) ? 1'b0 : 1'b1;
            tick();
            exp = {n != 3, n != 4, n == 5, n == 4};
            n_vec++;
            if ({sync_a, filt_a, rise_a, fall_a} !== exp) begin
                n_err++;
                $display("FAIL alt_glitch n=%0d got=%b want=%b", n, {sync_a, filt_a, rise_a, fall_a}, exp);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        sig   = 2'b10;
        sig_a = 1'b0;
        test_reset();
        test_clean_step();
        test_glitch();
        test_simultaneous();
        test_reset_mid_count();
        test_alt_config();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
